// File: rtl/hazard_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_controller                                            |
// | Description : Load-use / branch / memory-wait sequencer for the 5-stage    |
// |               core. Optional counters under HAZARD_PERF_CNT_EN.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module hazard_controller #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 15,
  parameter int CNT_WIDTH         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       IDEX_Mem_Read_i,
  input  logic [4:0] IDEX_Rd_i,
  input  logic [4:0] IFID_Rs1_i,
  input  logic [4:0] IFID_Rs2_i,
  input  logic       Branch_Taken_i,
  input  logic       Mem_Req_i,
  input  logic       Mem_Ready_i,
  output logic       PC_Write_o,
  output logic       IFID_Write_o,
  output logic       IFID_Flush_o,
  output logic       IDEX_Flush_o,
  output logic       Control_Disable_o,
  output logic       Pipe_Freeze_o,
  output logic       Mem_Error_o,
  output logic [1:0] State_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] Stall_Count_o,
  output logic [CNT_WIDTH-1:0] Flush_Count_o
`endif
);

  localparam logic [1:0] c_RUN        = 2'd0;
  localparam logic [1:0] c_LOAD_STALL = 2'd1;
  localparam logic [1:0] c_MEM_WAIT   = 2'd2;

  localparam logic [1:0] c_STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] c_TIMEOUT    = 8'(MEM_TIMEOUT);

  logic [1:0] r_state;
  logic [1:0] r_resume;
  logic [1:0] r_stall_cnt;
  logic [7:0] r_wait_cnt;
  logic       r_mem_error;

  logic       w_hz;
  logic       w_wait;
  logic [1:0] w_eff_state;
  logic [1:0] w_state_nxt;
  logic [1:0] w_resume_nxt;
  logic [1:0] w_stall_cnt_nxt;
  logic [7:0] w_wait_cnt_nxt;
  logic       w_err_set;

  assign w_hz   = IDEX_Mem_Read_i && (IDEX_Rd_i != 5'd0) &&
                  ((IDEX_Rd_i == IFID_Rs1_i) || (IDEX_Rd_i == IFID_Rs2_i));
  assign w_wait = Mem_Req_i && !Mem_Ready_i;

  // On the release cycle of MEM_WAIT the pipeline behaves as the interrupted state.
  assign w_eff_state = (r_state == c_MEM_WAIT) ? r_resume : r_state;

  always_comb begin
    w_state_nxt     = c_RUN;
    w_resume_nxt    = r_resume;
    w_stall_cnt_nxt = r_stall_cnt;
    w_wait_cnt_nxt  = 8'd0;
    if (w_wait) begin
      case (r_state)
        c_RUN, c_LOAD_STALL: begin
          w_state_nxt    = c_MEM_WAIT;
          w_resume_nxt   = r_state;
          w_wait_cnt_nxt = 8'd1;
        end
        c_MEM_WAIT: begin
          w_state_nxt    = c_MEM_WAIT;
          w_wait_cnt_nxt = (r_wait_cnt == 8'hFF) ? r_wait_cnt : (r_wait_cnt + 8'd1);
        end
        default: w_state_nxt = c_RUN;
      endcase
    end else begin
      case (w_eff_state)
        c_RUN: begin
          if (w_hz && !Branch_Taken_i && (LOAD_STALL_CYCLES > 1)) begin
            w_state_nxt     = c_LOAD_STALL;
            w_stall_cnt_nxt = c_STALL_INIT;
          end
        end
        c_LOAD_STALL: begin
          if (r_stall_cnt > 2'd1) begin
            w_state_nxt     = c_LOAD_STALL;
            w_stall_cnt_nxt = r_stall_cnt - 2'd1;
          end else begin
            w_stall_cnt_nxt = 2'd0;
          end
        end
        default: w_state_nxt = c_RUN;
      endcase
    end
  end

  assign w_err_set = (w_state_nxt == c_MEM_WAIT) && (w_wait_cnt_nxt >= c_TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_RUN;
      r_resume    <= c_RUN;
      r_stall_cnt <= 2'd0;
      r_wait_cnt  <= 8'd0;
      r_mem_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_resume    <= w_resume_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_mem_error <= r_mem_error || w_err_set;
    end
  end

  always_comb begin
    PC_Write_o        = 1'b1;
    IFID_Write_o      = 1'b1;
    IFID_Flush_o      = 1'b0;
    IDEX_Flush_o      = 1'b0;
    Control_Disable_o = 1'b0;
    Pipe_Freeze_o     = 1'b0;
    if (!reset) begin
      PC_Write_o        = 1'b0;
      IFID_Write_o      = 1'b0;
      Control_Disable_o = 1'b1;
    end else if (w_wait) begin
      PC_Write_o    = 1'b0;
      IFID_Write_o  = 1'b0;
      Pipe_Freeze_o = 1'b1;
    end else if ((w_eff_state == c_RUN) && Branch_Taken_i) begin
      // Branch beats a hazard: the ID instruction is wrong-path anyway.
      IFID_Flush_o      = 1'b1;
      IDEX_Flush_o      = 1'b1;
      Control_Disable_o = 1'b1;
    end else if (((w_eff_state == c_RUN) && w_hz) || (w_eff_state == c_LOAD_STALL)) begin
      PC_Write_o        = 1'b0;
      IFID_Write_o      = 1'b0;
      Control_Disable_o = 1'b1;
    end
  end

  assign Mem_Error_o = r_mem_error;
  assign State_o     = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic [CNT_WIDTH-1:0] r_flush_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (!PC_Write_o && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_WIDTH'(1);
      end
      if (IFID_Flush_o && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_WIDTH'(1);
      end
    end
  end

  assign Stall_Count_o = r_stall_count;
  assign Flush_Count_o = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hazard_controller                                         |
// | Description : Directed bench; two instances (1- and 3-cycle load stall).   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_hazard_controller;

  // Packed output view: {PC_W, IFID_W, IFID_FL, IDEX_FL, DIS, FRZ, ERR, STATE[1:0]}
  localparam logic [8:0] c_RSTO      = 9'b000010000;
  localparam logic [8:0] c_RUNO      = 9'b110000000;
  localparam logic [8:0] c_STL0      = 9'b000010000;
  localparam logic [8:0] c_STL1      = 9'b000010001;
  localparam logic [8:0] c_FLS       = 9'b111110000;
  localparam logic [8:0] c_FRZ0      = 9'b000001000;
  localparam logic [8:0] c_FRZ1      = 9'b000001001;
  localparam logic [8:0] c_FRZ2      = 9'b000001010;
  localparam logic [8:0] c_FRZ0E     = 9'b000001100;
  localparam logic [8:0] c_FRZ2E     = 9'b000001110;
  localparam logic [8:0] c_REL_RUN   = 9'b110000010;
  localparam logic [8:0] c_REL_STL   = 9'b000010010;
  localparam logic [8:0] c_REL_RUN_E = 9'b110000110;
  localparam logic [8:0] c_RUN_E     = 9'b110000100;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_read;
  logic [4:0] rd, rs1, rs2;
  logic       br, req, rdy;

  logic       a_pcw, a_ifw, a_iff, a_idf, a_dis, a_frz, a_err;
  logic [1:0] a_st;
  logic       b_pcw, b_ifw, b_iff, b_idf, b_dis, b_frz, b_err;
  logic [1:0] b_st;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(15), .CNT_WIDTH(16)) u_ls1 (
    .clk(clk), .reset(reset),
    .IDEX_Mem_Read_i(mem_read), .IDEX_Rd_i(rd), .IFID_Rs1_i(rs1), .IFID_Rs2_i(rs2),
    .Branch_Taken_i(br), .Mem_Req_i(req), .Mem_Ready_i(rdy),
    .PC_Write_o(a_pcw), .IFID_Write_o(a_ifw), .IFID_Flush_o(a_iff), .IDEX_Flush_o(a_idf),
    .Control_Disable_o(a_dis), .Pipe_Freeze_o(a_frz), .Mem_Error_o(a_err), .State_o(a_st)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_Count_o(a_scnt), .Flush_Count_o(a_fcnt)
`endif
  );

  hazard_controller #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(15), .CNT_WIDTH(16)) u_ls3 (
    .clk(clk), .reset(reset),
    .IDEX_Mem_Read_i(mem_read), .IDEX_Rd_i(rd), .IFID_Rs1_i(rs1), .IFID_Rs2_i(rs2),
    .Branch_Taken_i(br), .Mem_Req_i(req), .Mem_Ready_i(rdy),
    .PC_Write_o(b_pcw), .IFID_Write_o(b_ifw), .IFID_Flush_o(b_iff), .IDEX_Flush_o(b_idf),
    .Control_Disable_o(b_dis), .Pipe_Freeze_o(b_frz), .Mem_Error_o(b_err), .State_o(b_st)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_Count_o(b_scnt), .Flush_Count_o(b_fcnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic i_mr, input logic [4:0] i_rd, input logic [4:0] i_rs1,
                        input logic [4:0] i_rs2, input logic i_br, input logic i_req,
                        input logic i_rdy);
    mem_read = i_mr;
    rd       = i_rd;
    rs1      = i_rs1;
    rs2      = i_rs2;
    br       = i_br;
    req      = i_req;
    rdy      = i_rdy;
  endtask

  // One cycle: outputs checked at the falling edge, then advance past the rising edge.
  task automatic step(input string tag, input logic [8:0] e1, input logic [8:0] e3);
    logic [8:0] o1;
    logic [8:0] o3;
    @(negedge clk);
    o1 = {a_pcw, a_ifw, a_iff, a_idf, a_dis, a_frz, a_err, a_st};
    o3 = {b_pcw, b_ifw, b_iff, b_idf, b_dis, b_frz, b_err, b_st};
    check_eq({tag, "/ls1"}, {23'd0, o1}, {23'd0, e1});
    check_eq({tag, "/ls3"}, {23'd0, o3}, {23'd0, e3});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    step("reset", c_RSTO, c_RSTO);
    reset = 1'b1;
    step("idle", c_RUNO, c_RUNO);

    // add x6,x5,x1 in ID behind a load to x5
    set_in(1, 5, 5, 1, 0, 0, 0);
    step("hz_c1", c_STL0, c_STL0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("hz_c2", c_RUNO, c_STL1);
    step("hz_c3", c_RUNO, c_STL1);
    step("hz_c4", c_RUNO, c_RUNO);
    set_in(0, 0, 0, 0, 1, 0, 0);
    step("br_only", c_FLS, c_FLS);
`ifdef HAZARD_PERF_CNT_EN
    check_eq("perf_stall/ls1", {16'd0, a_scnt}, 32'd1);
    check_eq("perf_flush/ls1", {16'd0, a_fcnt}, 32'd1);
    check_eq("perf_stall/ls3", {16'd0, b_scnt}, 32'd3);
    check_eq("perf_flush/ls3", {16'd0, b_fcnt}, 32'd1);
`endif

    set_in(1, 0, 0, 0, 0, 0, 0);
    step("rd_zero", c_RUNO, c_RUNO);
    set_in(0, 5, 5, 1, 0, 0, 0);
    step("no_load", c_RUNO, c_RUNO);
    set_in(1, 7, 3, 7, 0, 0, 0);
    step("rs2_c1", c_STL0, c_STL0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("rs2_c2", c_RUNO, c_STL1);
    step("rs2_c3", c_RUNO, c_STL1);
    step("rs2_c4", c_RUNO, c_RUNO);

    set_in(1, 5, 5, 1, 1, 0, 0);
    step("br_hz", c_FLS, c_FLS);
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("br_hz_after", c_RUNO, c_RUNO);

    // Memory wait landing in the second LOAD_STALL cycle of the 3-cycle stall
    set_in(1, 5, 5, 1, 0, 0, 0);
    step("ws_hz", c_STL0, c_STL0);
    set_in(0, 0, 0, 0, 1, 0, 0);
    step("ws_br_in_stall", c_FLS, c_STL1);
    set_in(0, 0, 0, 0, 0, 1, 0);
    step("ws_frz1", c_FRZ0, c_FRZ1);
    set_in(1, 5, 5, 1, 1, 1, 0);
    step("ws_frz2", c_FRZ2, c_FRZ2);
    set_in(0, 0, 0, 0, 0, 1, 0);
    step("ws_frz3", c_FRZ2, c_FRZ2);
    step("ws_frz4", c_FRZ2, c_FRZ2);
    set_in(0, 0, 0, 0, 0, 1, 1);
    step("ws_release", c_REL_RUN, c_REL_STL);
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("ws_run", c_RUNO, c_RUNO);

    // Ready held low for 20 cycles: error visible from the 15th MEM_WAIT cycle
    set_in(0, 0, 0, 0, 0, 1, 0);
    step("to_k0", c_FRZ0, c_FRZ0);
    for (int k = 1; k < 20; k++) begin
      step($sformatf("to_k%0d", k), (k >= 15) ? c_FRZ2E : c_FRZ2, (k >= 15) ? c_FRZ2E : c_FRZ2);
    end
    set_in(0, 0, 0, 0, 0, 1, 1);
    step("to_release", c_REL_RUN_E, c_REL_RUN_E);
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("to_sticky", c_RUN_E, c_RUN_E);

    set_in(0, 0, 0, 0, 0, 1, 0);
    step("rw_c0", c_FRZ0E, c_FRZ0E);
    step("rw_c1", c_FRZ2E, c_FRZ2E);
    step("rw_c2", c_FRZ2E, c_FRZ2E);
    reset = 1'b0;
    step("rw_reset", c_RSTO, c_RSTO);
`ifdef HAZARD_PERF_CNT_EN
    check_eq("perf_clr_stall", {16'd0, a_scnt}, 32'd0);
    check_eq("perf_clr_flush", {16'd0, b_fcnt}, 32'd0);
`endif
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("rw_after", c_RUNO, c_RUNO);
    set_in(0, 0, 0, 0, 0, 1, 0);
    step("rw_new_wait", c_FRZ0, c_FRZ0);
    step("rw_new_wait2", c_FRZ2, c_FRZ2);
    set_in(0, 0, 0, 0, 0, 0, 0);
    step("rw_new_done", c_REL_RUN, c_REL_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
